fir_decim_buf: RTL and testbench
================================

// Module: fir_decim_buf
// PURPOSE
//  Downstream stage of the 8-bit FIR filter. Consumes the filter's vout/dout sample stream and keeps
//  every DECIM-th sample of each burst. Kept samples are buffered in a small FIFO and presented on a
//  valid/ready port, so a stalling consumer never loses FIR output unless the buffer overflows.
//  Burst boundaries are recovered from idle gaps on the input stream.
// PARAMETERS
//  DW       8   sample width; matches FIR dout
//  DECIM    4   decimation ratio (>=1; 1 = pass-through)
//  DEPTH    16  FIFO entries (power of two, >=2)
//  GAP_CYC  8   consecutive idle input cycles that close a burst (>=1)
// PORTS
//  clock       in   1              system clock; all logic on rising edge
//  reset       in   1              asynchronous, active-high reset
//  vin         in   1              input sample valid (from FIR vout)
//  din         in   DW             input sample (from FIR dout)
//  vout        out  1              output sample valid
//  dout        out  DW             output sample
//  rdy         in   1              consumer ready; transfer when vout&rdy at rising edge
//  level       out  $clog2(DEPTH)+1  FIFO occupancy
//  ovf         out  1              sticky overflow flag
//  burst_done  out  1              one-cycle pulse when a burst is closed
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; phase = 0; gap counter = 0; FSM = IDLE. Reset is asynchronous and
//    can be asserted at any time; it discards buffered data with no end-of-burst pulse.
//  FSM states:
//    IDLE -> BURST on the first vin=1.
//    BURST:
//      - vin=1 clears the gap counter.
//      - vin=0 increments the gap counter.
//      - When the gap counter reaches GAP_CYC, go to IDLE, pulse burst_done for 1 cycle, set phase = 0.
//    An idle gap shorter than GAP_CYC does not close the burst; phase continues.
//  Phase:
//    - Advances by 1 on every vin=1 and wraps from DECIM-1 to 0.
//    - A sample is kept when vin=1 and phase==0, so the first sample of every burst is kept.
//  FIFO write:
//    - A kept sample is written on the same edge.
//    - It is visible on dout with vout=1 in the following cycle (first-word-fall-through, latency 1).
//    - There is no bypass: an empty FIFO gives vout=0 in the cycle the write occurs.
//  FIFO read:
//    - On vout&rdy, the head entry is popped and the next entry (if any) appears in the following cycle.
//    - dout holds its value while vout=1 and rdy=0.
//  Full:
//    - A write with level==DEPTH and no simultaneous pop drops the sample and sets ovf.
//    - ovf stays 1 until reset.
//    - A write and pop in the same cycle while full succeeds; level is unchanged.
//  Empty: a pop is impossible because vout=0.
//  Level: simultaneous write+pop leaves level unchanged.
//  Pointer wrap: read and write pointers wrap modulo DEPTH; level uses an extra bit so 0 and DEPTH are
//    distinct.
//  Same-cycle events:
//    - vin=1 in the cycle the gap counter would reach GAP_CYC: the burst continues and no pulse occurs.
//    - A burst closing and a FIFO pop in the same cycle are independent.
// STRUCTURE
//  Package fir_pkg: DW; FSM state enum {S_IDLE, S_BURST}; helper constant for the level width.
//  Sub-module fir_sfifo: synchronous FWFT FIFO with DW and DEPTH parameters, ports wr/wdata/rd/rdata/
//    empty/full/level. It is instantiated once.
//  Top-level contents: FSM, phase counter, gap counter, ovf logic.
// TESTING
//  1. DECIM=4, rdy=1, burst of 32 samples din=0..31 -> dout 0,4,8,...,28 (8 samples); each vout occurs
//     1 cycle after its input cycle; burst_done pulses once, GAP_CYC cycles after the last vin.
//  2. Two bursts of 32 separated by a 20-cycle gap, second burst din=100..131 -> second burst output
//     starts at 100 (phase restarted); 2 burst_done pulses.
//  3. Burst of 10 samples, a 3-cycle gap (< GAP_CYC), then 10 more samples, din=0..19 -> outputs
//     0,4,8,12,16; a single burst_done.
//  4. DECIM=1, rdy=0, 32 samples din=0..31 -> level=16, ovf=1 from the 17th write. Then rdy=1 ->
//     dout=0..15 in order, level returns to 0, ovf stays 1.
//  5. Full FIFO, then vin kept sample and rdy=1 in the same cycle -> write accepted, level stays 16,
//     ovf stays 0.
//  6. reset asserted mid-burst with level=5 -> outputs go 0 asynchronously; no burst_done pulse.
//     After release, a new burst din=50.. -> first output is 50.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR decimating output buffer.
//   DW       default sample width (matches FIR dout)
//   state_t  burst tracker states
//   lvl_w()  width of a FIFO occupancy count; one bit wider than the
//            pointer so that empty (0) and full (DEPTH) are distinct.
package fir_pkg;
  localparam int DW = 8;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fir_sfifo.sv
// Synchronous first-word-fall-through FIFO.
//   clock, reset : rising-edge clock, async active-high reset
//   wr, wdata    : write request / data (dropped when full unless popping)
//   rd           : pop request (ignored when empty)
//   rdata        : head entry, valid whenever empty==0 (0 when empty)
//   empty, full  : occupancy flags
//   level        : occupancy, 0..DEPTH
module fir_sfifo
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [DW-1:0]              wdata,
  input  logic                       rd,
  output logic [DW-1:0]              rdata,
  output logic                       empty,
  output logic                       full,
  output logic [lvl_w(DEPTH)-1:0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_wr, do_rd;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign do_rd = rd & ~empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO
  // still lands; the head is read out before the edge overwrites it.
  assign do_wr = wr & (~full | do_rd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; visibility is governed by level.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr];
endmodule

// File: rtl/fir_decim_buf.sv
// Keeps every DECIM-th sample of each FIR output burst and buffers the
// kept samples for a valid/ready consumer. A burst ends after GAP_CYC
// consecutive idle input cycles, which restarts the decimation phase.
//   clock, reset     : rising-edge clock, async active-high reset
//   vin, din         : input sample stream from the FIR
//   vout, dout, rdy  : buffered output, transfer on vout&rdy
//   level            : buffer occupancy
//   ovf              : sticky, set when a kept sample is dropped
//   burst_done       : one-cycle pulse when a burst closes
module fir_decim_buf
  import fir_pkg::*;
#(
  parameter int DW      = fir_pkg::DW,
  parameter int DECIM   = 4,
  parameter int DEPTH   = 16,
  parameter int GAP_CYC = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     vin,
  input  logic [DW-1:0]            din,
  output logic                     vout,
  output logic [DW-1:0]            dout,
  input  logic                     rdy,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     ovf,
  output logic                     burst_done
);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  state_t        state;
  logic [PW-1:0] phase;
  logic [GW-1:0] gap;
  logic          keep, empty, full, pop;

  assign keep = vin & (phase == '0);
  assign vout = ~empty;
  assign pop  = vout & rdy;

  fir_sfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr    (keep),
    .wdata (din),
    .rd    (rdy),
    .rdata (dout),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= '0;
      gap        <= '0;
      ovf        <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (keep && full && !pop) ovf <= 1'b1;
      // A sample always wins over gap expiry, so the burst survives.
      if (vin) begin
        state <= S_BURST;
        gap   <= '0;
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end else if (state == S_BURST) begin
        if (gap == GAP_LAST) begin
          state      <= S_IDLE;
          gap        <= '0;
          phase      <= '0;
          burst_done <= 1'b1;
        end else begin
          gap <= gap + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_decim_buf.sv
// Bench for fir_decim_buf: one DECIM=4 instance (index 0) and one DECIM=1
// instance (index 1) against a queue-based reference model, plus directed
// output-sequence checks.
module tb_fir_decim_buf;
  localparam int DW = 8, DEPTH = 16, GAP = 8, LW = 5;

  logic                 tb_clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           vin, rdy, vout, ovf, done;
  logic [1:0][DW-1:0]   din, dout;
  logic [1:0][LW-1:0]   level;

  always #5 tb_clk = ~tb_clk;

  fir_decim_buf #(.DW(DW), .DECIM(4), .DEPTH(DEPTH), .GAP_CYC(GAP)) u_d4 (
    .clock(tb_clk), .reset(rst), .vin(vin[0]), .din(din[0]), .vout(vout[0]),
    .dout(dout[0]), .rdy(rdy[0]), .level(level[0]), .ovf(ovf[0]), .burst_done(done[0]));

  fir_decim_buf #(.DW(DW), .DECIM(1), .DEPTH(DEPTH), .GAP_CYC(GAP)) u_d1 (
    .clock(tb_clk), .reset(rst), .vin(vin[1]), .din(din[1]), .vout(vout[1]),
    .dout(dout[1]), .rdy(rdy[1]), .level(level[1]), .ovf(ovf[1]), .burst_done(done[1]));

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: sample count within burst, idle run length, queue.
  int         m_dec [2] = '{4, 1};
  int         m_cnt [2], m_idle [2];
  bit         m_inb [2], m_ovf [2], m_done [2];
  logic [7:0] q0 [$], q1 [$];

  initial begin
    int  sz;
    bit  kp;
    forever begin
      @(posedge tb_clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          m_cnt[i] = 0; m_idle[i] = 0; m_inb[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
        end
        q0.delete(); q1.delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          sz = (i == 0) ? q0.size() : q1.size();
          if (sz > 0 && rdy[i]) begin
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            sz--;
          end
          kp = vin[i] && (m_cnt[i] % m_dec[i] == 0);
          if (kp) begin
            if (sz < DEPTH) begin
              if (i == 0) q0.push_back(din[i]); else q1.push_back(din[i]);
            end else m_ovf[i] = 1;
          end
          m_done[i] = 0;
          if (vin[i]) begin
            m_inb[i] = 1; m_idle[i] = 0; m_cnt[i]++;
          end else if (m_inb[i]) begin
            m_idle[i]++;
            if (m_idle[i] == GAP) begin
              m_inb[i] = 0; m_done[i] = 1; m_cnt[i] = 0; m_idle[i] = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus output collection.
  logic [7:0] got0 [$], got1 [$];
  int         nd [2] = '{0, 0};

  initial begin
    int sz;
    logic [7:0] hd;
    forever begin
      @(negedge tb_clk);
      for (int i = 0; i < 2; i++) begin
        sz = (i == 0) ? q0.size() : q1.size();
        chk($sformatf("d%0d_vout", i), vout[i], sz > 0);
        chk($sformatf("d%0d_level", i), level[i], sz);
        chk($sformatf("d%0d_ovf", i), ovf[i], m_ovf[i]);
        chk($sformatf("d%0d_done", i), done[i], m_done[i]);
        if (sz > 0) begin
          hd = (i == 0) ? q0[0] : q1[0];
          chk($sformatf("d%0d_dout", i), dout[i], hd);
        end
        if (done[i]) nd[i]++;
        if (vout[i] && rdy[i]) begin
          if (i == 0) got0.push_back(dout[i]); else got1.push_back(dout[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge tb_clk); #1;
  endtask

  task automatic idle(input int i, input int n);
    vin[i] = 1'b0;
    repeat (n) step();
  endtask

  task automatic burst(input int i, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      vin[i] = 1'b1; din[i] = 8'(base + k);
      step();
    end
    vin[i] = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] q [$],
                         input int first, input int stride, input int n);
    chk({tag, "_cnt"}, q.size(), n);
    for (int k = 0; k < n && k < q.size(); k++)
      chk($sformatf("%s_%0d", tag, k), q[k], first + stride * k);
  endtask

  initial begin
    int nd0;
    int gapc [2];
    vin = '0; rdy = 2'b11; din = '0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_vout", vout[i], 0);
      chk("rst_level", level[i], 0);
      chk("rst_ovf", ovf[i], 0);
      chk("rst_done", done[i], 0);
    end
    rst = 1'b0;
    step();

    // 1: single burst, every 4th sample, one close pulse
    got0.delete(); nd[0] = 0;
    burst(0, 0, 32); idle(0, 20);
    chk_seq("t1", got0, 0, 4, 8);
    chk("t1_pulses", nd[0], 1);

    // 2: second burst restarts phase
    got0.delete();
    burst(0, 100, 32); idle(0, 20);
    chk_seq("t2", got0, 100, 4, 8);
    chk("t2_pulses", nd[0], 2);

    // 3: short gap keeps the burst open
    got0.delete(); nd[0] = 0;
    burst(0, 0, 10); idle(0, 3); burst(0, 10, 10); idle(0, 20);
    chk_seq("t3", got0, 0, 4, 5);
    chk("t3_pulses", nd[0], 1);

    // 4: pass-through, stalled consumer, overflow on the 17th write
    rdy[1] = 1'b0;
    for (int k = 0; k < 32; k++) begin
      vin[1] = 1'b1; din[1] = 8'(k);
      step();
      if (k == 15) begin chk("t4_ovf16", ovf[1], 0); chk("t4_lvl16", level[1], 16); end
      if (k == 16) chk("t4_ovf17", ovf[1], 1);
    end
    vin[1] = 1'b0; step();
    chk("t4_full", level[1], 16);
    got1.delete(); rdy[1] = 1'b1;
    idle(1, 20);
    chk_seq("t4", got1, 0, 1, 16);
    chk("t4_empty", level[1], 0);
    chk("t4_sticky", ovf[1], 1);

    // 6: async reset mid-burst with 5 buffered
    rdy[0] = 1'b0;
    burst(0, 0, 17);
    chk("t6_lvl", level[0], 5);
    nd0 = nd[0];
    @(posedge tb_clk); #3;
    rst = 1'b1; #1;
    chk("t6_vout", vout[0], 0);
    chk("t6_level", level[0], 0);
    chk("t6_ovf1", ovf[1], 0);
    step(); step();
    rst = 1'b0; rdy[0] = 1'b1;
    idle(0, 12);
    chk("t6_nopulse", nd[0], nd0);
    got0.delete();
    burst(0, 50, 8); idle(0, 20);
    chk_seq("t6", got0, 50, 4, 2);
    chk("t6_pulse", nd[0], nd0 + 1);

    // 5: write and pop together while full
    rdy[1] = 1'b0;
    burst(1, 0, 16);
    chk("t5_lvl", level[1], 16);
    chk("t5_ovf0", ovf[1], 0);
    got1.delete();
    vin[1] = 1'b1; din[1] = 8'd200; rdy[1] = 1'b1;
    step();
    vin[1] = 1'b0;
    chk("t5_lvl_same", level[1], 16);
    chk("t5_ovf_same", ovf[1], 0);
    idle(1, 20);
    chk("t5_cnt", got1.size(), 17);
    for (int k = 0; k < 16 && k < got1.size(); k++) chk($sformatf("t5_%0d", k), got1[k], k);
    if (got1.size() == 17) chk("t5_last", got1[16], 200);

    // Random traffic against the model
    gapc = '{0, 0};
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (gapc[i] > 0) begin
          vin[i] = 1'b0; gapc[i]--;
        end else if ($urandom_range(0, 99) < 4) begin
          gapc[i] = $urandom_range(3, 12); vin[i] = 1'b0;
        end else begin
          vin[i] = ($urandom_range(0, 99) < 60);
        end
        din[i] = 8'($urandom);
        rdy[i] = ($urandom_range(0, 99) < 55);
      end
      step();
    end
    vin = '0; rdy = 2'b11;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
